// File: rtl/aer_pkg.sv
// Shared widths, AER word layout and block state encoding for the event packer.
package aer_pkg;

  localparam int AER_X_W    = 2;
  localparam int AER_Y_W    = 2;
  localparam int AER_TS_W   = 16;
  localparam int AER_DEPTH  = 8;
  localparam int AER_DROP_W = 16;

  localparam logic AER_TYPE_EVT  = 1'b0;
  localparam logic AER_TYPE_WRAP = 1'b1;

  typedef struct packed {
    logic                typ;
    logic [AER_TS_W-1:0] ts;
    logic [AER_X_W-1:0]  x;
    logic [AER_Y_W-1:0]  y;
    logic                pol;
  } aer_word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_STALL  = 2'd2
  } aer_state_e;

endpackage

// File: rtl/aer_event_packer_if.sv
// Grant input and AER output stream of the event packer; slave is the packer's view.
interface aer_event_packer_if
  import aer_pkg::*;
#(
  parameter int X_W  = AER_X_W,
  parameter int Y_W  = AER_Y_W,
  parameter int TS_W = AER_TS_W
) ();

  localparam int W = 1 + TS_W + X_W + Y_W + 1;

  logic           evt_valid_i;
  logic [X_W-1:0] xadd_i;
  logic [Y_W-1:0] yadd_i;
  logic           pol_i;
  logic           evt_ready_o;

  logic [W-1:0]   aer_data_o;
  logic           aer_valid_o;
  logic           aer_ready_i;

  modport slave (
    input  evt_valid_i, xadd_i, yadd_i, pol_i, aer_ready_i,
    output evt_ready_o, aer_data_o, aer_valid_o
  );

  modport master (
    output evt_valid_i, xadd_i, yadd_i, pol_i, aer_ready_i,
    input  evt_ready_o, aer_data_o, aer_valid_o
  );

endinterface

// File: rtl/aer_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count.
module aer_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign count_o = r_count;
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  // Empty FIFO presents zeros rather than stale storage.
  assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !reset_i && !flush_i) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/aer_event_packer.sv
// Stamps arbiter grants with a free-running timestamp, packs them into AER words and
// streams them through a FIFO, inserting wrap markers and counting lost entries.
//
// state     | meaning
// ST_IDLE   | FIFO and skid empty
// ST_STREAM | FIFO holds words, skid empty
// ST_STALL  | skid holds an accepted event waiting for a FIFO slot
module aer_event_packer
  import aer_pkg::*;
#(
  parameter int X_W    = AER_X_W,
  parameter int Y_W    = AER_Y_W,
  parameter int TS_W   = AER_TS_W,
  parameter int DEPTH  = AER_DEPTH,
  parameter int DROP_W = AER_DROP_W
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    flush_i,
  aer_event_packer_if.slave       bus,
  output logic [$clog2(DEPTH):0]  fifo_level_o,
  output logic [DROP_W-1:0]       drop_cnt_o
);

  localparam int W     = 1 + TS_W + X_W + Y_W + 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  aer_state_e        r_state;
  aer_state_e        w_state_next;
  logic [TS_W-1:0]   r_ts;
  logic              r_marker_pend;
  logic [W-1:0]      r_skid_data;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [DROP_W:0]   w_drop_sum;

  logic              w_skid_vld;
  logic              w_evt_ready;
  logic              w_accept;
  logic              w_wrap;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_marker_wr;
  logic              w_skid_wr;
  logic              w_evt_direct;
  logic              w_skid_load;
  logic              w_drop_evt;
  logic              w_drop_wrap;
  logic [W-1:0]      w_evt_word;
  logic [W-1:0]      w_wdata;
  logic [W-1:0]      w_rdata;
  logic [LVL_W-1:0]  w_count;
  logic [LVL_W-1:0]  w_level_next;

  // The skid register is occupied exactly while the block is stalled.
  assign w_skid_vld  = (r_state == ST_STALL);
  assign w_evt_ready = !w_skid_vld;
  assign w_accept    = enable_i && bus.evt_valid_i && w_evt_ready && !flush_i;
  assign w_wrap      = enable_i && (&r_ts);
  assign w_evt_word  = {AER_TYPE_EVT, r_ts, bus.xadd_i, bus.yadd_i, bus.pol_i};
  assign w_pop       = !w_empty && bus.aer_ready_i;

  // One write per cycle: pending marker, then skid entry, then the new event.
  always_comb begin
    w_push       = 1'b0;
    w_wdata      = '0;
    w_marker_wr  = 1'b0;
    w_skid_wr    = 1'b0;
    w_evt_direct = 1'b0;
    if (!flush_i && !w_full) begin
      if (r_marker_pend) begin
        w_push      = 1'b1;
        w_wdata     = {AER_TYPE_WRAP, {(W-1){1'b0}}};
        w_marker_wr = 1'b1;
      end else if (w_skid_vld) begin
        w_push    = 1'b1;
        w_wdata   = r_skid_data;
        w_skid_wr = 1'b1;
      end else if (w_accept) begin
        w_push       = 1'b1;
        w_wdata      = w_evt_word;
        w_evt_direct = 1'b1;
      end
    end
  end

  assign w_skid_load  = w_accept && !w_evt_direct;
  assign w_level_next = w_count + LVL_W'(w_push) - LVL_W'(w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_skid_load)      w_state_next = ST_STALL;
        else if (w_push)      w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_skid_load)                w_state_next = ST_STALL;
        else if (w_level_next == '0)    w_state_next = ST_IDLE;
      end
      ST_STALL: begin
        if (w_skid_wr)        w_state_next = ST_STREAM;
      end
      default:                w_state_next = ST_IDLE;
    endcase
    if (flush_i) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)       r_ts <= '0;
    else if (enable_i) r_ts <= r_ts + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) r_marker_pend <= 1'b0;
    else if (w_wrap)        r_marker_pend <= 1'b1;
    else if (w_marker_wr)   r_marker_pend <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)          r_skid_data <= '0;
    else if (w_skid_load) r_skid_data <= w_evt_word;
  end

  // A wrap is lost only if the previous marker is still waiting for a slot.
  assign w_drop_evt  = !flush_i && enable_i && bus.evt_valid_i && !w_evt_ready;
  assign w_drop_wrap = !flush_i && w_wrap && r_marker_pend && !w_marker_wr;
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {{DROP_W{1'b0}}, w_drop_evt}
                     + {{DROP_W{1'b0}}, w_drop_wrap};

  always_ff @(posedge clk_i) begin
    if (reset_i)                r_drop_cnt <= '0;
    else if (w_drop_sum[DROP_W]) r_drop_cnt <= '1;
    else                        r_drop_cnt <= w_drop_sum[DROP_W-1:0];
  end

  aer_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .push_i  (w_push),
    .wdata_i (w_wdata),
    .pop_i   (w_pop),
    .rdata_o (w_rdata),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

  assign bus.evt_ready_o = w_evt_ready;
  assign bus.aer_data_o  = w_rdata;
  assign bus.aer_valid_o = !w_empty;
  assign fifo_level_o    = w_count;
  assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_aer_event_packer.sv
// Directed bench: table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_aer_event_packer;
  import aer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, fl, en_w, fl_w;
  logic [3:0]  lvl, lvl_w;
  logic [15:0] drop, drop_w;
  int          total = 0;
  int          bad = 0;
  int          ts_m = 0;
  int          ts_w = 0;

  aer_event_packer_if #(.X_W(2), .Y_W(2), .TS_W(16)) b ();
  aer_event_packer_if #(.X_W(2), .Y_W(2), .TS_W(4))  bw ();

  aer_event_packer #(.X_W(2), .Y_W(2), .TS_W(16), .DEPTH(8), .DROP_W(16)) dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .flush_i(fl),
    .bus(b), .fifo_level_o(lvl), .drop_cnt_o(drop));

  aer_event_packer #(.X_W(2), .Y_W(2), .TS_W(4), .DEPTH(8), .DROP_W(16)) dut_w (
    .clk_i(clk), .reset_i(rst), .enable_i(en_w), .flush_i(fl_w),
    .bus(bw), .fifo_level_o(lvl_w), .drop_cnt_o(drop_w));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en, ev;
    logic [1:0]  x, y;
    logic        pol, rdy;
    logic        e_valid;
    logic [21:0] e_data;
    logic [3:0]  e_lvl;
    logic        e_rdy;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [21:0] mk(logic t, logic [15:0] ts, logic [1:0] x, logic [1:0] y,
                                     logic p);
    aer_word_t w;
    w.typ = t; w.ts = ts; w.x = x; w.y = y; w.pol = p;
    return w;
  endfunction

  function automatic logic [9:0] mkw(logic t, logic [3:0] ts, logic [1:0] x, logic [1:0] y,
                                     logic p);
    return {t, ts, x, y, p};
  endfunction

  function automatic vec_t v(logic en_, logic ev_, logic [1:0] x_, logic [1:0] y_, logic p_,
                             logic rdy_, logic ev_valid, logic [21:0] ed, logic [3:0] el,
                             logic er, logic [15:0] edr);
    vec_t r;
    r.en = en_; r.ev = ev_; r.x = x_; r.y = y_; r.pol = p_; r.rdy = rdy_;
    r.e_valid = ev_valid; r.e_data = ed; r.e_lvl = el; r.e_rdy = er; r.e_drop = edr;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (en) ts_m++;
    if (en_w) ts_w = (ts_w + 1) % 16;
    @(posedge clk);
    #1;
  endtask

  task automatic set_evt(logic ev_, logic [1:0] x_, logic [1:0] y_, logic p_);
    b.evt_valid_i = ev_; b.xadd_i = x_; b.yadd_i = y_; b.pol_i = p_;
  endtask

  logic [21:0] q[$];
  logic [21:0] exp_w;
  int          n_mark, n_other;

  initial begin
    rst = 1'b1; en = 1'b0; fl = 1'b0; en_w = 1'b0; fl_w = 1'b0;
    set_evt(1'b0, 2'd0, 2'd0, 1'b0);
    b.aer_ready_i = 1'b0;
    bw.evt_valid_i = 1'b0; bw.xadd_i = '0; bw.yadd_i = '0; bw.pol_i = 1'b0;
    bw.aer_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ts_m = 0; ts_w = 0;

    chk("rst_valid", 64'(b.aer_valid_o), 64'd0);
    chk("rst_data",  64'(b.aer_data_o),  64'd0);
    chk("rst_level", 64'(lvl),           64'd0);
    chk("rst_ready", 64'(b.evt_ready_o), 64'd1);
    chk("rst_drop",  64'(drop),          64'd0);
    chk("rst_w_valid", 64'(bw.aer_valid_o), 64'd0);

    // ts 0..4 idle, event at ts=5, then mixed push/pop and disabled pulses
    for (int i = 0; i < 5; i++) tbl[i] = v(1, 0, 0, 0, 0, 1, 0, 22'd0, 4'd0, 1, 16'd0);
    tbl[5]  = v(1, 1, 2, 1, 1, 0, 1, mk(0, 16'd5, 2, 1, 1), 4'd1, 1, 16'd0);
    tbl[6]  = v(1, 1, 1, 3, 0, 0, 1, mk(0, 16'd5, 2, 1, 1), 4'd2, 1, 16'd0);
    tbl[7]  = v(0, 1, 2, 2, 1, 1, 1, mk(0, 16'd6, 1, 3, 0), 4'd1, 1, 16'd0);
    tbl[8]  = v(0, 1, 3, 3, 0, 0, 1, mk(0, 16'd6, 1, 3, 0), 4'd1, 1, 16'd0);
    tbl[9]  = v(1, 1, 3, 0, 1, 1, 1, mk(0, 16'd7, 3, 0, 1), 4'd1, 1, 16'd0);
    tbl[10] = v(1, 0, 0, 0, 0, 1, 0, 22'd0, 4'd0, 1, 16'd0);

    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en;
      set_evt(tbl[i].ev, tbl[i].x, tbl[i].y, tbl[i].pol);
      b.aer_ready_i = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(b.aer_valid_o), 64'(tbl[i].e_valid));
      chk($sformatf("vec%0d_data", i),  64'(b.aer_data_o),  64'(tbl[i].e_data));
      chk($sformatf("vec%0d_level", i), 64'(lvl),           64'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_ready", i), 64'(b.evt_ready_o), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_drop", i),  64'(drop),          64'(tbl[i].e_drop));
    end

    // fill to full, ninth into skid, tenth dropped, then drain in order
    b.aer_ready_i = 1'b0;
    en = 1'b1;
    q.delete();
    for (int i = 0; i < 10; i++) begin
      set_evt(1'b1, 2'(i), 2'(i >> 2), 1'(i));
      if (i < 9) q.push_back(mk(0, 16'(ts_m), 2'(i), 2'(i >> 2), 1'(i)));
      tick();
      if (i == 7) begin
        chk("fill8_level", 64'(lvl), 64'd8);
        chk("fill8_ready", 64'(b.evt_ready_o), 64'd1);
      end
      if (i == 8) begin
        chk("skid_level", 64'(lvl), 64'd8);
        chk("skid_ready", 64'(b.evt_ready_o), 64'd0);
        chk("skid_drop",  64'(drop), 64'd0);
      end
      if (i == 9) begin
        chk("drop10_cnt",   64'(drop), 64'd1);
        chk("drop10_ready", 64'(b.evt_ready_o), 64'd0);
      end
    end
    set_evt(1'b0, 2'd0, 2'd0, 1'b0);
    en = 1'b0;
    b.aer_ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(b.aer_valid_o), 64'd1);
      chk($sformatf("drain%0d_data", k),  64'(b.aer_data_o),  64'(q[k]));
      tick();
    end
    chk("drain_end_valid", 64'(b.aer_valid_o), 64'd0);
    chk("drain_end_ready", 64'(b.evt_ready_o), 64'd1);

    // pop and push on a full FIFO: the push waits in the skid
    b.aer_ready_i = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_evt(1'b1, 2'(i), 2'd1, 1'b0);
      tick();
    end
    chk("full_level", 64'(lvl), 64'd8);
    set_evt(1'b1, 2'd3, 2'd3, 1'b1);
    b.aer_ready_i = 1'b1;
    chk("poppush_level_same", 64'(lvl), 64'd8);
    tick();
    chk("poppush_level_after", 64'(lvl), 64'd7);
    chk("poppush_ready", 64'(b.evt_ready_o), 64'd0);
    set_evt(1'b0, 2'd0, 2'd0, 1'b0);
    b.aer_ready_i = 1'b0;
    tick();
    chk("skid_drain_level", 64'(lvl), 64'd8);
    chk("skid_drain_ready", 64'(b.evt_ready_o), 64'd1);
    set_evt(1'b1, 2'd2, 2'd2, 1'b0);
    tick();
    chk("preflush_ready", 64'(b.evt_ready_o), 64'd0);

    // flush with FIFO full and skid loaded; the flush-cycle event is not counted
    fl = 1'b1;
    set_evt(1'b1, 2'd1, 2'd0, 1'b1);
    tick();
    fl = 1'b0;
    set_evt(1'b0, 2'd0, 2'd0, 1'b0);
    chk("flush_valid", 64'(b.aer_valid_o), 64'd0);
    chk("flush_level", 64'(lvl), 64'd0);
    chk("flush_ready", 64'(b.evt_ready_o), 64'd1);
    chk("flush_drop",  64'(drop), 64'd1);
    exp_w = mk(0, 16'(ts_m), 2'd1, 2'd1, 1'b0);
    set_evt(1'b1, 2'd1, 2'd1, 1'b0);
    tick();
    set_evt(1'b0, 2'd0, 2'd0, 1'b0);
    chk("postflush_ts", 64'(b.aer_data_o), 64'(exp_w));
    chk("postflush_level", 64'(lvl), 64'd1);
    en = 1'b0;
    b.aer_ready_i = 1'b1;
    tick();
    chk("postflush_empty", 64'(b.aer_valid_o), 64'd0);

    // disabled grants are ignored and the timestamp holds
    for (int i = 0; i < 3; i++) begin
      set_evt(1'b1, 2'(i), 2'd2, 1'b1);
      tick();
      chk($sformatf("dis%0d_valid", i), 64'(b.aer_valid_o), 64'd0);
      chk($sformatf("dis%0d_drop", i),  64'(drop), 64'd1);
    end
    en = 1'b1;
    exp_w = mk(0, 16'(ts_m), 2'd3, 2'd2, 1'b1);
    set_evt(1'b1, 2'd3, 2'd2, 1'b1);
    tick();
    en = 1'b0;
    set_evt(1'b0, 2'd0, 2'd0, 1'b0);
    chk("held_ts_data", 64'(b.aer_data_o), 64'(exp_w));
    tick();
    chk("held_ts_empty", 64'(b.aer_valid_o), 64'd0);

    // 4-bit timestamp: one marker per wrap, then an event in the wrap cycle
    bw.aer_ready_i = 1'b1;
    en_w = 1'b1;
    n_mark = 0;
    n_other = 0;
    for (int c = 0; c < 36; c++) begin
      if (bw.aer_valid_o) begin
        if (bw.aer_data_o == mkw(1, 4'd0, 2'd0, 2'd0, 1'b0)) n_mark++;
        else n_other++;
      end
      tick();
    end
    chk("wrap_markers", 64'(n_mark), 64'd2);
    chk("wrap_others",  64'(n_other), 64'd0);
    for (int c = 0; c < 32 && ts_w != 15; c++) tick();
    chk("wrap_reach_15", 64'(ts_w), 64'd15);
    tick();
    bw.evt_valid_i = 1'b1; bw.xadd_i = 2'd1; bw.yadd_i = 2'd2; bw.pol_i = 1'b1;
    tick();
    bw.evt_valid_i = 1'b0;
    chk("wrapevt_marker_valid", 64'(bw.aer_valid_o), 64'd1);
    chk("wrapevt_marker_data",  64'(bw.aer_data_o), 64'(mkw(1, 4'd0, 2'd0, 2'd0, 1'b0)));
    chk("wrapevt_ready_low",    64'(bw.evt_ready_o), 64'd0);
    tick();
    chk("wrapevt_evt_valid", 64'(bw.aer_valid_o), 64'd1);
    chk("wrapevt_evt_data",  64'(bw.aer_data_o), 64'(mkw(0, 4'd0, 2'd1, 2'd2, 1'b1)));
    chk("wrapevt_ready_high", 64'(bw.evt_ready_o), 64'd1);
    tick();
    chk("wrapevt_empty", 64'(bw.aer_valid_o), 64'd0);
    chk("wrapevt_drop",  64'(drop_w), 64'd0);
    en_w = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aer_event_packer.md
# aer_event_packer

Downstream stage of the row/column arbitration tree in the pixel hierarchy. Each time the arbiters grant a pixel, this block captures the granted x/y address and polarity. It stamps the event with a free-running timestamp and packs it into an address-event (AER) word. It then buffers the word in a small FIFO and presents it on a valid/ready stream, inserting timestamp-wrap markers and counting dropped events.

## Interface
Parameters:
- X_W, 2, width of x address (row arbiter index)
- Y_W, 2, width of y address (column arbiter index)
- TS_W, 16, timestamp counter width
- DEPTH, 8, FIFO entries, power of two, ≥ 2
- DROP_W, 16, drop counter width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; one clock, reset is synchronous and active-high
- enable_i  in  1  advances timestamp and allows event capture
- flush_i  in  1  synchronous clear of FIFO, skid and pending marker
- evt_valid_i  in  1  one-cycle strobe: new grant this cycle
- xadd_i  in  X_W  granted x address
- yadd_i  in  Y_W  granted y address
- pol_i  in  1  event polarity
- evt_ready_o  out  1  high when skid register empty
- aer_data_o  out  W  packed word, W = 1+TS_W+X_W+Y_W+1
- aer_valid_o  out  1  FIFO not empty
- aer_ready_i  in  1  consumer accepts word
- fifo_level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt_o  out  DROP_W  saturating count of lost events/markers

## Operation
- Word layout MSB→LSB: {type, ts, x, y, pol}. Event: type=0. Wrap marker: type=1, all other fields 0.
- Timestamp ts:
  - increments by 1 each cycle enable_i=1 and holds otherwise.
  - Transition from all-ones to 0 sets marker_pend.
  - If marker_pend is already set when the wrap occurs, drop_cnt increments.
- Event accept:
  - Condition: enable_i && evt_valid_i && evt_ready_o.
  - The event captures the ts value of the cycle it arrives.
  - If evt_valid_i arrives while enable_i=1 and evt_ready_o=0, the event is dropped and drop_cnt increments.
  - If evt_valid_i arrives while enable_i=0, it is ignored and not counted.
- One FIFO write per cycle, fixed priority: marker_pend > skid entry > new event.
  - An accepted event that cannot be written that cycle (FIFO full, or a higher-priority write) goes into the skid register.
- Full check uses the current count. No push while full, even if a pop occurs the same cycle.
- FIFO is show-ahead: aer_data_o = head entry. Pop on aer_valid_o && aer_ready_i.
- drop_cnt saturates at all-ones. It is cleared only by reset_i; flush_i does not clear it.
- flush_i: empties FIFO and skid, clears marker_pend. ts and drop_cnt are unaffected. An event arriving in the flush cycle is discarded and not counted.
- Block states:
  - IDLE: FIFO and skid empty.
  - STREAM: FIFO non-empty, skid empty.
  - STALL: skid full.
  - STALL→STREAM once the skid entry is written.

## Timing
- Reset: ts=0, FIFO empty, skid empty, marker_pend=0, drop_cnt=0, aer_valid_o=0, aer_data_o=0, fifo_level_o=0, evt_ready_o=1.
- Latency: event at cycle N into an empty FIFO → aer_valid_o=1 with that word at N+1.
- Skid path: event at N stalled by a marker → marker visible N+1, event enqueued N+1, event at head N+2 if the marker is popped at N+1.
- evt_ready_o is registered. It falls the cycle after the skid loads and rises the cycle after the skid drains.
- Once raised, aer_valid_o stays high until the word is popped. aer_data_o is stable while valid && !ready.
- Reset or flush mid-stream takes effect at the next edge and overrides all other actions.

## Structure
- Package aer_pkg holds:
  - field widths;
  - typedef aer_word_t (packed struct type/ts/x/y/pol);
  - localparam AER_TYPE_EVT=0 and AER_TYPE_WRAP=1.
- Sub-module aer_sync_fifo: parameterised width/depth, show-ahead, sync reset plus flush, count output.
- Top level holds the ts counter, marker_pend, skid register, write-priority mux and drop counter.

## Test plan
- Reset, then evt_valid_i with x=2, y=1, pol=1 at ts=5 → next cycle aer_valid_o=1, data={0,5,2,1,1}, fifo_level_o=1.
- TS_W=4: run 16 enabled cycles with aer_ready_i=1 → marker {1,0,0,0,0} appears once per wrap; an event in the wrap cycle follows the marker and keeps its captured ts.
- aer_ready_i=0, DEPTH=8:
  - 8 events → fifo_level_o=8.
  - 9th event → skid, evt_ready_o=0.
  - 10th event → drop_cnt_o=1.
  - Release ready → 9 words emitted in order.
- Pop and push while full → the push is held in the skid and fifo_level_o stays 8 that cycle.
- flush_i with 5 words queued and skid full → next cycle aer_valid_o=0, evt_ready_o=1, drop_cnt_o unchanged.
- enable_i=0 with evt_valid_i pulses → no words, ts held, drop_cnt_o unchanged.
